// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray-code helpers
package fifo_pkg;

  // Default geometry shared by fifo_mem, the write-side and read-side control blocks
  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 1 << ADDRSIZE;
  localparam int PTRW     = ADDRSIZE + 1;

  // Helpers operate on a zero-extended 32-bit vector so any pointer width up to
  // 32 bits can use them; callers size-cast the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down: b[i] = g[31] ^ ... ^ g[i]
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// rtl/sync_r2w.sv - two-flop synchroniser for a Gray pointer crossing into wclk
module sync_r2w
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTRW
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-1:0] wq2_rptr
);

  logic [WIDTH-1:0] r_wq1_rptr;
  logic [WIDTH-1:0] r_wq2_rptr;

  // Two-stage chain: the foreign Gray pointer settles in stage 1, stage 2 is used
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wq1_rptr <= '0;
      r_wq2_rptr <= '0;
    end else begin
      r_wq1_rptr <= rptr;
      r_wq2_rptr <= r_wq1_rptr;
    end
  end

  assign wq2_rptr = r_wq2_rptr;

endmodule

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write pointer, full, almost-full, count and overflow
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = fifo_pkg::ADDRSIZE,
  parameter int AF_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                overflow_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int              PW   = ADDRSIZE + 1;
  localparam logic [PW-1:0]   AF_T = PW'(AF_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_wfull;
  logic          r_walmost_full;
  logic [PW-1:0] r_wcount;
  logic          r_woverflow;

  logic [PW-1:0] w_wq2_rptr;
  logic          w_push;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_full_match;
  logic          w_full_next;
  logic [PW-1:0] w_rbin_sync;
  logic [PW-1:0] w_wcount_next;
  logic          w_almost_next;

  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst     (wrst),
    .rptr     (rptr),
    .wq2_rptr (w_wq2_rptr)
  );

  // A write is only accepted when not full; an overflowing write never moves the pointer
  assign w_push       = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDRSIZE{1'b0}}, w_push};
  assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));

  // Full when the next write pointer has lapped the read pointer by exactly DEPTH:
  // in Gray code that is the top two bits inverted and the rest equal
  assign w_full_match = {~w_wq2_rptr[PW-1:PW-2], w_wq2_rptr[PW-3:0]};
  assign w_full_next  = (w_wgray_next == w_full_match);

  // Count against the stale synchronised read pointer, so it can only overstate the fill
  assign w_rbin_sync   = PW'(gray2bin(32'(w_wq2_rptr)));
  assign w_wcount_next = w_wbin_next - w_rbin_sync;
  assign w_almost_next = (w_wcount_next >= AF_T);

  // Pointer, flags and count all advance together on each write-clock edge
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wcount       <= '0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_walmost_full <= w_almost_next;
      r_wcount       <= w_wcount_next;
    end
  end

  // Sticky overflow; a new overflow on the clearing edge keeps the flag set
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_woverflow <= 1'b0;
    end else if (winc & r_wfull) begin
      r_woverflow <= 1'b1;
    end else if (overflow_clr) begin
      r_woverflow <= 1'b0;
    end
  end

  assign waddr        = r_wbin[ADDRSIZE-1:0];
  assign wclken       = w_push;
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wcount       = r_wcount;
  assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - directed table-driven bench for fifo_wptr_full
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] rptr = '0;
  logic       overflow_clr = 1'b0;
  logic [3:0] waddr;
  logic       wclken;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wptr_full #(
    .ADDRSIZE  (4),
    .AF_THRESH (12)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .overflow_clr (overflow_clr),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       clr;
    logic       e_wclken;
    logic [3:0] e_waddr;
    logic [4:0] e_wptr;
    logic       e_wfull;
    logic       e_af;
    logic [4:0] e_wcount;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] gray5(input int i);
    logic [4:0] b;
    b = i[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic void add(input logic wi, input logic [4:0] rp, input logic cl,
                              input logic ce, input logic [3:0] wa, input logic [4:0] wp,
                              input logic wf, input logic af, input logic [4:0] wc,
                              input logic ov);
    vec_t v;
    v.winc = wi; v.rptr = rp; v.clr = cl; v.e_wclken = ce; v.e_waddr = wa;
    v.e_wptr = wp; v.e_wfull = wf; v.e_af = af; v.e_wcount = wc; v.e_ovf = ov;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1; winc = 1'b0; rptr = '0; overflow_clr = 1'b0;
    step();
    step();
    wrst = 1'b0;
  endtask

  initial begin
    logic [4:0] prev_wptr;
    logic [4:0] h1;
    logic [4:0] h2;
    int         wraps;

    // Reset state
    do_reset();
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_af", walmost_full, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_ovf", woverflow, 0);
    chk("rst_wclken", wclken, 0);

    // Fill: 16 writes with rptr parked at 0
    for (int i = 1; i <= 16; i++)
      add(1, 5'd0, 0, 1, 4'(i % 16), gray5(i), (i == 16), (i >= 12), 5'(i), 0);
    // Overflow from full, then clear, then set and clear on the same edge
    add(1, 5'd0, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    add(1, 5'd0, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    add(0, 5'd0, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    add(0, 5'd0, 1, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    add(1, 5'd0, 1, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    add(0, 5'd0, 1, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    // Drain visibility: rptr -> gray(4), full drops on the third edge
    add(0, 5'b00110, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    add(0, 5'b00110, 0, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 0);
    add(0, 5'b00110, 0, 0, 4'd0, 5'b11000, 0, 1, 5'd12, 0);
    // rptr -> gray(5): count 11 drops below the threshold
    add(0, 5'b00111, 0, 0, 4'd0, 5'b11000, 0, 1, 5'd12, 0);
    add(0, 5'b00111, 0, 0, 4'd0, 5'b11000, 0, 1, 5'd12, 0);
    add(0, 5'b00111, 0, 0, 4'd0, 5'b11000, 0, 0, 5'd11, 0);

    foreach (vecs[k]) begin
      winc = vecs[k].winc; rptr = vecs[k].rptr; overflow_clr = vecs[k].clr;
      #1;
      chk($sformatf("v%0d_wclken", k), wclken, vecs[k].e_wclken);
      step();
      chk($sformatf("v%0d_waddr", k), waddr, vecs[k].e_waddr);
      chk($sformatf("v%0d_wptr", k), wptr, vecs[k].e_wptr);
      chk($sformatf("v%0d_wfull", k), wfull, vecs[k].e_wfull);
      chk($sformatf("v%0d_af", k), walmost_full, vecs[k].e_af);
      chk($sformatf("v%0d_wcount", k), wcount, vecs[k].e_wcount);
      chk($sformatf("v%0d_ovf", k), woverflow, vecs[k].e_ovf);
    end
    winc = 0; overflow_clr = 0;

    // Wrap streaming: rptr follows wptr two cycles late
    do_reset();
    h1 = '0; h2 = '0; wraps = 0;
    for (int i = 1; i <= 40; i++) begin
      winc = 1'b1;
      rptr = h2;
      #1;
      chk("wrap_wclken", wclken, 1);
      prev_wptr = wptr;
      step();
      chk("wrap_wfull", wfull, 0);
      chk("wrap_onebit", $countones(wptr ^ prev_wptr), 1);
      chk("wrap_waddr", waddr, i % 16);
      if (waddr == 4'd0) wraps++;
      h2 = h1;
      h1 = wptr;
    end
    winc = 1'b0;
    chk("wrap_count", wraps, 2);

    // Reset mid-operation between clock edges
    do_reset();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    chk("pre_rst_wcount", wcount, 5);
    #2;
    wrst = 1'b1;
    #1;
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_wfull", wfull, 0);
    chk("mid_rst_af", walmost_full, 0);
    chk("mid_rst_wcount", wcount, 0);
    chk("mid_rst_ovf", woverflow, 0);
    chk("mid_rst_wclken0", wclken, 0);
    winc = 1'b1;
    #1;
    chk("mid_rst_wclken1", wclken, 1);
    winc = 1'b0;
    wrst = 1'b0;
    #1;
    winc = 1'b1;
    #1;
    chk("post_rst_waddr", waddr, 0);
    chk("post_rst_wclken", wclken, 1);
    step();
    winc = 1'b0;
    chk("post_rst_waddr1", waddr, 1);
    chk("post_rst_wptr", wptr, 5'b00001);
    chk("post_rst_wcount", wcount, 1);

    // Simultaneous push and read-pointer advance at count 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    chk("sim_wcount8", wcount, 8);
    winc = 1'b1;
    rptr = 5'b00001;
    step();
    winc = 1'b0;
    chk("sim_e1_wcount", wcount, 9);
    step();
    chk("sim_e2_wcount", wcount, 9);
    step();
    chk("sim_e3_wcount", wcount, 8);
    chk("sim_wfull", wfull, 0);
    chk("sim_af", walmost_full, 0);
    chk("sim_wptr", wptr, gray5(9));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side control stage that sits directly upstream of fifo_mem in the async FIFO. It owns the binary/Gray write pointer and drives fifo_mem's waddr, wclken and wfull. It synchronises the read-domain Gray pointer into wclk and produces the full flag, an almost-full flag, a pessimistic fill count and a sticky overflow error.

Parameters:
ADDRSIZE, 4, memory address bits; must match fifo_mem ADDRSIZE; DEPTH = 1<<ADDRSIZE.
AF_THRESH, 12, fill count at or above which walmost_full asserts; legal range 1..DEPTH.

Ports:
wclk  input  1  write clock; the only clock in the block.
wrst  input  1  reset, asynchronous, active-high.
winc  input  1  write request from producer.
rptr  input  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to wclk.
overflow_clr  input  1  clears woverflow.
waddr  output  ADDRSIZE  write address to fifo_mem.
wclken  output  1  write enable to fifo_mem.
wptr  output  ADDRSIZE+1  registered Gray write pointer, to the read-side synchroniser.
wfull  output  1  FIFO full, to fifo_mem and producer.
walmost_full  output  1  fill count >= AF_THRESH.
wcount  output  ADDRSIZE+1  registered fill count as seen from the write domain.
woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (wrst high, async): wbin, wptr, both sync stages, wfull, walmost_full, wcount and woverflow all go to 0 immediately. waddr=0. wclken=winc.
- Deassertion is taken on a wclk edge with no special handling. Reset mid-operation discards all pointer state; fifo_mem contents are not touched.
- Sync: wq2_rptr is a 2-flop register chain of rptr. The synchronised value lags rptr by 2 wclk edges.
- Accept: push = winc & ~wfull. wclken = push, combinational.
- Pointer update:
  - wbin_next = wbin + push, mod 2^(ADDRSIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - wbin and wptr are registered from these on every edge.
  - waddr = wbin[ADDRSIZE-1:0]; it wraps DEPTH-1 -> 0 naturally.
- Full (registered): wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Asserts on the same edge that accepts the DEPTH-th word.
  - Deasserts 3 wclk edges after rptr advances: 2 for sync, 1 for the flag register.
- Count (registered): wcount <= wbin_next - gray2bin(wq2_rptr), mod 2^(ADDRSIZE+1).
  - Never exceeds DEPTH. It may overstate the true fill because the read pointer is stale; it never understates it.
- Almost full (registered): walmost_full <= (wcount_next >= AF_THRESH). It is therefore always 1 while wfull is 1.
- Overflow: woverflow sets on any edge where winc & wfull, and clears on an edge where overflow_clr is high.
  - If set and clear occur on the same edge, set wins.
  - An overflowing write never moves the pointer and never asserts wclken.
- Simultaneous events:
  - A push and a read-pointer advance are evaluated together; the count uses both updated values.
  - With winc held high while full, writes resume on the first edge where wfull is 0.
- All outputs except wclken are registered. Gray wptr changes by exactly one bit per accepted write, including the wrap 2*DEPTH-1 -> 0.

Decomposition:
- Shared package fifo_pkg:
  - function bin2gray(ADDRSIZE+1).
  - function gray2bin(ADDRSIZE+1), XOR prefix.
  - Default ADDRSIZE/DEPTH constants, shared by fifo_mem, this block and the read-side block.
- One sub-module: sync_r2w, a parameterised 2-flop synchroniser (wclk, wrst, rptr -> wq2_rptr). The read side later reuses it as sync_w2r.

Test Plan:
Use ADDRSIZE=4 and AF_THRESH=12 throughout.
1. Fill: rptr=0, 16 winc pulses -> wclken high 16 cycles, waddr 0..15 then 0, wptr=5'b11000, wfull=1 after 16th edge, wcount=16, walmost_full=1 from 12th edge.
2. Overflow: from full, winc for 2 cycles -> wclken=0, waddr/wptr unchanged, woverflow=1. woverflow stays 1 until overflow_clr pulse. Overflow_clr coincident with winc&wfull -> woverflow stays 1.
3. Drain visibility: from full, rptr=gray(4)=5'b00110 -> wfull 0 exactly 3 edges later, wcount=12, walmost_full=1. Then rptr=gray(5)=5'b00111 -> wcount=11, walmost_full=0.
4. Wrap streaming: 40 words written while rptr tracks wptr with 2-cycle lag -> wfull never asserts, waddr wraps 15->0 twice, every wptr transition differs in exactly one bit.
5. Reset mid-operation: after 5 writes, pulse wrst between clock edges -> all outputs 0 before the next edge. After release, the first write goes to waddr=0.
6. Simultaneous push and read: wcount=8, winc with rptr advancing by one -> wcount settles at 8 once the sync lag elapses. wfull and walmost_full unchanged.
